// File: rtl/mem_arbiter.sv
// Shares one single-ported memory between the instruction-fetch and data paths.
// Each granted request is latched and run through a variable-latency enable/ready handshake guarded by a watchdog.
module mem_arbiter #(
  parameter int          STARVE_LIMIT = 4,
  parameter int          TIMEOUT      = 64,
  parameter logic [31:0] ERR_WORD     = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_done,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic        m_enable,
  output logic        m_rw,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_ready,
  output logic        busy,
  output logic        err
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [TW-1:0] WDOG_LAST  = TW'(TIMEOUT - 1);

  logic [0:0]    state_r;
  logic          owner_d_r;
  logic          we_r;
  logic [SW-1:0] starve_r;
  logic [TW-1:0] wdog_r;
  logic          grant_d_s;
  logic          grant_if_s;

  // Arbitration: data wins unless fetch has waited through STARVE_LIMIT data grants
  always_comb begin
    grant_d_s  = 1'b0;
    grant_if_s = 1'b0;
    if (state_r == IDLE) begin
      if (d_req && !(if_req && (starve_r == STARVE_MAX))) begin
        grant_d_s = 1'b1;
      end else if (if_req) begin
        grant_if_s = 1'b1;
      end else begin
        grant_d_s  = 1'b0;
        grant_if_s = 1'b0;
      end
    end else begin
      grant_d_s  = 1'b0;
      grant_if_s = 1'b0;
    end
  end

  // Transaction sequencer, starvation counter, watchdog and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      owner_d_r <= 1'b0;
      we_r      <= 1'b0;
      starve_r  <= '0;
      wdog_r    <= '0;
      m_enable  <= 1'b0;
      m_rw      <= 1'b0;
      m_addr    <= 32'h0000_0000;
      m_wdata   <= 32'h0000_0000;
      busy      <= 1'b0;
      err       <= 1'b0;
      if_done   <= 1'b0;
      d_done    <= 1'b0;
      if_rdata  <= 32'h0000_0000;
      d_rdata   <= 32'h0000_0000;
    end else begin
      if_done <= 1'b0;
      d_done  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (grant_d_s || grant_if_s) begin
            state_r   <= BUSY;
            owner_d_r <= grant_d_s;
            we_r      <= grant_d_s & d_we;
            m_addr    <= grant_d_s ? d_addr : if_addr;
            m_wdata   <= d_wdata;
            m_rw      <= grant_d_s ? ~d_we : 1'b1;
            m_enable  <= 1'b1;
            busy      <= 1'b1;
            wdog_r    <= '0;
            if (grant_if_s || !if_req) begin
              starve_r <= '0;
            end else if (starve_r != STARVE_MAX) begin
              starve_r <= starve_r + SW'(1);
            end
          end
        end
        BUSY: begin
          if (m_ready) begin
            state_r  <= IDLE;
            m_enable <= 1'b0;
            busy     <= 1'b0;
            if (owner_d_r) begin
              d_done <= 1'b1;
              if (!we_r) begin
                d_rdata <= m_rdata;
              end
            end else begin
              if_done  <= 1'b1;
              if_rdata <= m_rdata;
            end
          end else if (wdog_r == WDOG_LAST) begin
            // Memory never answered: return a recognisable word and flag it
            state_r  <= IDLE;
            m_enable <= 1'b0;
            busy     <= 1'b0;
            err      <= 1'b1;
            if (owner_d_r) begin
              d_done  <= 1'b1;
              d_rdata <= ERR_WORD;
            end else begin
              if_done  <= 1'b1;
              if_rdata <= ERR_WORD;
            end
          end else begin
            wdog_r <= wdog_r + TW'(1);
          end
        end
        default: begin
          state_r  <= IDLE;
          m_enable <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with default parameters.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_done;
  logic        m_enable;
  logic        m_rw;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        m_ready;
  logic        busy;
  logic        err;

  int n_cmp;
  int n_err;

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done),
    .m_enable(m_enable), .m_rw(m_rw), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ready(m_ready), .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (obs !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    int grants;
    int cnt;
    n_cmp   = 0;
    n_err   = 0;
    reset   = 1'b1;
    if_req  = 1'b0;
    if_addr = 32'h0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_addr  = 32'h0;
    d_wdata = 32'h0;
    m_rdata = 32'h0;
    m_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
    check_eq("rst_enable", {31'd0, m_enable}, 32'd0);
    check_eq("rst_busy",   {31'd0, busy}, 32'd0);
    check_eq("rst_done",   {30'd0, if_done, d_done}, 32'd0);
    check_eq("rst_err",    {31'd0, err}, 32'd0);

    // Single fetch with memory ready in the first BUSY cycle
    if_req = 1'b1; if_addr = 32'h40; m_ready = 1'b1; m_rdata = 32'h2008_0005;
    step();
    check_eq("f_enable", {31'd0, m_enable}, 32'd1);
    check_eq("f_rw",     {31'd0, m_rw}, 32'd1);
    check_eq("f_addr",   m_addr, 32'h40);
    check_eq("f_nodone", {31'd0, if_done}, 32'd0);
    step();
    check_eq("f_done",   {31'd0, if_done}, 32'd1);
    check_eq("f_rdata",  if_rdata, 32'h2008_0005);
    check_eq("f_en_off", {31'd0, m_enable}, 32'd0);
    if_req = 1'b0; m_ready = 1'b0;
    step();
    check_eq("f_pulse",  {31'd0, if_done}, 32'd0);

    // Simultaneous requests: data write first, fetch next
    if_req = 1'b1; if_addr = 32'h44;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hCAFE;
    m_ready = 1'b1; m_rdata = 32'h1111_1111;
    step();
    check_eq("s_rw",    {31'd0, m_rw}, 32'd0);
    check_eq("s_addr",  m_addr, 32'h100);
    check_eq("s_wdata", m_wdata, 32'hCAFE);
    step();
    check_eq("s_ddone", {30'd0, d_done, if_done}, 32'd2);
    check_eq("s_drdata_kept", d_rdata, 32'h0);
    d_req = 1'b0;
    step();
    check_eq("s_faddr", m_addr, 32'h44);
    check_eq("s_frw",   {31'd0, m_rw}, 32'd1);
    step();
    check_eq("s_fdone", {30'd0, d_done, if_done}, 32'd1);
    check_eq("s_frdata", if_rdata, 32'h1111_1111);
    if_req = 1'b0; m_ready = 1'b0;
    step();

    // Starvation: four data grants then one fetch, repeating
    if_req = 1'b1; if_addr = 32'h80; d_req = 1'b1; d_we = 1'b1; d_addr = 32'h180;
    m_ready = 1'b1;
    grants = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (busy) begin
        check_eq($sformatf("starve_g%0d", grants), {31'd0, m_rw}, ((grants % 5) == 4) ? 32'd1 : 32'd0);
        grants = grants + 1;
      end
    end
    check_eq("starve_cnt", grants, 32'd10);
    if_req = 1'b0; d_req = 1'b0; m_ready = 1'b0;
    step();

    // Timeout on a data read
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200; m_ready = 1'b0;
    step();
    cnt = 0;
    while (busy && cnt < 100) begin
      cnt = cnt + 1;
      step();
    end
    d_req = 1'b0;
    check_eq("to_cycles", cnt, 32'd64);
    check_eq("to_done",   {31'd0, d_done}, 32'd1);
    check_eq("to_rdata",  d_rdata, 32'hDEADBEEF);
    check_eq("to_err",    {31'd0, err}, 32'd1);
    step();
    d_req = 1'b1; d_addr = 32'h204; m_ready = 1'b1; m_rdata = 32'h1234_5678;
    step();
    check_eq("to_next_addr", m_addr, 32'h204);
    step();
    check_eq("to_next_done",  {31'd0, d_done}, 32'd1);
    check_eq("to_next_rdata", d_rdata, 32'h1234_5678);
    check_eq("to_err_sticky", {31'd0, err}, 32'd1);
    d_req = 1'b0; m_ready = 1'b0;
    step();

    // Reset on the third BUSY cycle, late ready afterwards
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h300; d_wdata = 32'h5;
    step();
    step();
    step();
    check_eq("rm_busy3", {31'd0, busy}, 32'd1);
    reset = 1'b1; d_req = 1'b0;
    step();
    check_eq("rm_ctl",    {26'd0, m_enable, m_rw, busy, err, if_done, d_done}, 32'd0);
    check_eq("rm_maddr",  m_addr, 32'h0);
    check_eq("rm_mwdata", m_wdata, 32'h0);
    check_eq("rm_ifrd",   if_rdata, 32'h0);
    check_eq("rm_drd",    d_rdata, 32'h0);
    reset = 1'b0; m_ready = 1'b1;
    step();
    check_eq("rm_late",   {29'd0, busy, if_done, d_done}, 32'd0);
    m_ready = 1'b0;
    step();

    // Requester inputs change during BUSY; 5-cycle memory latency
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h400; d_wdata = 32'hA5A5_A5A5;
    step();
    d_addr = 32'h999; d_wdata = 32'h0;
    for (int i = 1; i <= 5; i++) begin
      check_eq($sformatf("ii_addr%0d", i),  m_addr, 32'h400);
      check_eq($sformatf("ii_wdata%0d", i), m_wdata, 32'hA5A5_A5A5);
      check_eq($sformatf("ii_done%0d", i),  {31'd0, d_done}, 32'd0);
      if (i == 5) m_ready = 1'b1;
      step();
    end
    check_eq("ii_done",  {31'd0, d_done}, 32'd1);
    check_eq("ii_rdata", d_rdata, 32'h0);
    check_eq("ii_enoff", {31'd0, m_enable}, 32'd0);
    d_req = 1'b0; m_ready = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
